// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module   : lsu
// Purpose  : Load/store unit between the execute stage and a word-addressed
//            data memory. Checks alignment/range, waits out the memory read
//            latency with a timeout, extracts and extends sub-word loads and
//            performs sub-word stores as read-modify-write.
// Options  : LSU_SUBWORD_EN - when defined, byte and halfword accesses are
//            supported; otherwise sizes 00/01 get an error response.
// Revision : 1.0 - initial release
// ============================================================================
module lsu #(
  parameter int NUMWORDS  = 4096,
  parameter int DATAWIDTH = 32,
  parameter int TIMEOUT   = 15,
  localparam int ADDR_SIZE = $clog2(NUMWORDS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [1:0]           req_size_i,
  input  logic                 req_unsigned_i,
  input  logic [31:0]          req_addr_i,
  input  logic [DATAWIDTH-1:0] req_wdata_i,
  output logic                 resp_valid_o,
  output logic [DATAWIDTH-1:0] resp_rdata_o,
  output logic                 resp_err_o,
  output logic                 mem_read_en_o,
  output logic [ADDR_SIZE-1:0] mem_read_addr_o,
  input  logic                 mem_read_valid_i,
  input  logic [DATAWIDTH-1:0] mem_read_data_i,
  output logic                 mem_write_en_o,
  output logic [ADDR_SIZE-1:0] mem_write_addr_o,
  output logic [DATAWIDTH-1:0] mem_write_data_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE, RESP} state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 ready_q;
  logic                 resp_valid_q;
  logic [31:0]          resp_rdata_q;
  logic                 resp_err_q;
  logic                 rd_en_q;
  logic [ADDR_SIZE-1:0] rd_addr_q;
  logic                 wr_en_q;
  logic [ADDR_SIZE-1:0] wr_addr_q;
  logic [31:0]          wr_data_q;

  logic                 req_err;
  logic [ADDR_SIZE-1:0] req_widx;
  logic [31:0]          load_data;

  assign req_widx = req_addr_i[ADDR_SIZE+1:2];

`ifdef LSU_SUBWORD_EN
  // Request attributes needed after acceptance for extract/merge.
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic [4:0]  lane_sh;
  logic [31:0] rd_shift;
  logic [31:0] lane_mask;
  logic [31:0] merge_data;

  assign lane_sh    = {off_q, 3'b000};
  assign rd_shift   = mem_read_data_i >> lane_sh;
  assign lane_mask  = ((size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << lane_sh;
  assign merge_data = (mem_read_data_i & ~lane_mask) | ((wdata_q << lane_sh) & lane_mask);

  // Pick the addressed lane out of the read word and extend it.
  always_comb begin
    load_data = rd_shift;
    case (size_q)
      2'b00:   load_data = uns_q ? {24'h0, rd_shift[7:0]}  : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   load_data = uns_q ? {16'h0, rd_shift[15:0]} : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: load_data = rd_shift;
    endcase
  end
`else
  logic w_unused;
  assign w_unused  = req_unsigned_i;
  assign load_data = mem_read_data_i;
`endif

  // Reject illegal sizes, misalignment and addresses beyond the memory.
  always_comb begin
    req_err = ((req_addr_i >> (ADDR_SIZE + 2)) != 32'h0);
    case (req_size_i)
      2'b10:   if (req_addr_i[1:0] != 2'b00) req_err = 1'b1;
`ifdef LSU_SUBWORD_EN
      2'b01:   if (req_addr_i[0]) req_err = 1'b1;
      2'b00:   req_err = req_err;
`endif
      default: req_err = 1'b1;
    endcase
  end

  // Main sequencer; every output is a register updated with the state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= 32'h0;
`ifdef LSU_SUBWORD_EN
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      off_q        <= 2'b00;
      wdata_q      <= 32'h0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            ready_q <= 1'b0;
`ifdef LSU_SUBWORD_EN
            we_q    <= req_we_i;
            size_q  <= req_size_i;
            uns_q   <= req_unsigned_i;
            off_q   <= req_addr_i[1:0];
            wdata_q <= req_wdata_i;
`endif
            if (req_err) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'h0;
            end else if (req_we_i && (req_size_i == 2'b10)) begin
              state_q   <= WRITE;
              wr_en_q   <= 1'b1;
              wr_addr_q <= req_widx;
              wr_data_q <= req_wdata_i;
            end else begin
              state_q   <= READ_WAIT;
              rd_en_q   <= 1'b1;
              rd_addr_q <= req_widx;
              cnt_q     <= '0;
            end
          end
        end
        READ_WAIT: begin
          if (mem_read_valid_i) begin
            rd_en_q <= 1'b0;
`ifdef LSU_SUBWORD_EN
            if (we_q) begin
              state_q   <= WRITE;
              wr_en_q   <= 1'b1;
              wr_addr_q <= rd_addr_q;
              wr_data_q <= merge_data;
            end else
`endif
            begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b0;
              resp_rdata_q <= load_data;
            end
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            rd_en_q      <= 1'b0;
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= 32'h0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WRITE: begin
          wr_en_q      <= 1'b0;
          state_q      <= RESP;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= 32'h0;
        end
        default: begin
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= 32'h0;
          ready_q      <= 1'b1;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign req_ready_o      = ready_q;
  assign resp_valid_o     = resp_valid_q;
  assign resp_rdata_o     = resp_rdata_q;
  assign resp_err_o       = resp_err_q;
  assign mem_read_en_o    = rd_en_q;
  assign mem_read_addr_o  = rd_addr_q;
  assign mem_write_en_o   = wr_en_q;
  assign mem_write_addr_o = wr_addr_q;
  assign mem_write_data_o = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu
// Purpose  : Directed self-checking bench for lsu. Sub-word expectations
//            follow the LSU_SUBWORD_EN build option.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu;

  localparam int AW = 12;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
  logic [1:0]    req_size_i;
  logic [31:0]   req_addr_i, req_wdata_i;
  logic          resp_valid_o, resp_err_o;
  logic [31:0]   resp_rdata_o;
  logic          mem_read_en_o, mem_read_valid_i, mem_write_en_o;
  logic [AW-1:0] mem_read_addr_o, mem_write_addr_o;
  logic [31:0]   mem_read_data_i, mem_write_data_o;

  int vectors = 0;
  int miscompares = 0;

  lsu #(.NUMWORDS(4096), .DATAWIDTH(32), .TIMEOUT(15)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o),
    .resp_err_o(resp_err_o), .mem_read_en_o(mem_read_en_o), .mem_read_addr_o(mem_read_addr_o),
    .mem_read_valid_i(mem_read_valid_i), .mem_read_data_i(mem_read_data_i),
    .mem_write_en_o(mem_write_en_o), .mem_write_addr_o(mem_write_addr_o),
    .mem_write_data_o(mem_write_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Issue one request at the current (ready) cycle and run it to completion.
  // Cycle n = n-th cycle after the accepting edge. vcyc=0 means never respond.
  task automatic transact(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd, input int vcyc,
                          input logic [31:0] rword, input logic [AW-1:0] raddr_exp,
                          output int rcyc, output logic [31:0] rdata, output logic err,
                          output int rdcnt, output int rdbad, output int wcnt, output int wcyc,
                          output logic [AW-1:0] waddr, output logic [31:0] wdat,
                          output logic rdy_c1, output logic rdy_resp, output logic idle_after);
    rcyc = -1; rdata = 'x; err = 1'bx; rdcnt = 0; rdbad = 0; wcnt = 0; wcyc = -1;
    waddr = '0; wdat = '0; rdy_c1 = 1'bx; rdy_resp = 1'bx;
    req_valid_i = 1'b1; req_we_i = we; req_size_i = sz; req_unsigned_i = uns;
    req_addr_i = addr; req_wdata_i = wd;
    tick();
    req_valid_i = 1'b0; req_addr_i = 32'hFFFF_FFFF; req_wdata_i = 32'h5555_5555;
    for (int n = 1; n <= 40 && rcyc < 0; n++) begin
      if (n == 1) rdy_c1 = req_ready_o;
      if (mem_read_en_o) begin
        rdcnt++;
        if (mem_read_addr_o !== raddr_exp) rdbad++;
      end
      if (mem_write_en_o) begin
        wcnt++; wcyc = n; waddr = mem_write_addr_o; wdat = mem_write_data_o;
      end
      if (resp_valid_o) begin
        rcyc = n; rdata = resp_rdata_o; err = resp_err_o; rdy_resp = req_ready_o;
      end
      mem_read_valid_i = (n == vcyc);
      mem_read_data_i  = (n == vcyc) ? rword : 32'hA5A5_5A5A;
      tick();
    end
    mem_read_valid_i = 1'b0;
    idle_after = req_ready_o && !resp_valid_o;
  endtask

  int rc, rdc, rdb, wc, wcy;
  logic [31:0] rd, wdt;
  logic er, r1, rr, ia;
  logic [AW-1:0] wa;

  task automatic test_reset();
    vectors++; if (req_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", req_ready_o); end
    vectors++; if (resp_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid_o); end
    vectors++; if (resp_rdata_o !== 32'h0 || resp_err_o !== 1'b0) begin miscompares++; $display("FAIL reset_resp: got %h/%b want 0/0", resp_rdata_o, resp_err_o); end
    vectors++; if ({mem_read_en_o, mem_write_en_o} !== 2'b00) begin miscompares++; $display("FAIL reset_enables: got %b want 00", {mem_read_en_o, mem_write_en_o}); end
    vectors++; if ({mem_read_addr_o, mem_write_addr_o, mem_write_data_o} !== '0) begin miscompares++; $display("FAIL reset_mem_bus: got %h %h %h want 0", mem_read_addr_o, mem_write_addr_o, mem_write_data_o); end
  endtask

  task automatic test_load_word();
    transact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 6, 32'hDEAD_BEEF, 12'd4, rc, rd, er, rdc, rdb, wc, wcy, wa, wdt, r1, rr, ia);
    vectors++; if (rc !== 7) begin miscompares++; $display("FAIL ldw_resp_cycle: got %0d want 7", rc); end
    vectors++; if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin miscompares++; $display("FAIL ldw_data: got %h/%b want deadbeef/0", rd, er); end
    vectors++; if (rdc !== 6 || rdb !== 0) begin miscompares++; $display("FAIL ldw_read_en: got cycles=%0d badaddr=%0d want 6/0", rdc, rdb); end
    vectors++; if (wc !== 0) begin miscompares++; $display("FAIL ldw_no_write: got %0d want 0", wc); end
    vectors++; if ({r1, rr, ia} !== 3'b001) begin miscompares++; $display("FAIL ldw_ready: got c1=%b resp=%b after=%b want 0/0/1", r1, rr, ia); end
  endtask

  // Word 4 = 0x80FF7F01; each row: addr, size, unsigned, extended value.
  task automatic test_load_subword();
    logic [31:0] t_addr [5] = '{32'h13, 32'h13, 32'h12, 32'h11, 32'h10};
    logic [1:0]  t_size [5] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b01};
    logic        t_uns  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] t_exp  [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_007F, 32'h0000_7F01};
    for (int i = 0; i < 5; i++) begin
      int e_rc, e_rdc; logic [31:0] e_rd; logic e_er;
`ifdef LSU_SUBWORD_EN
      e_rc = 2; e_rd = t_exp[i]; e_er = 1'b0; e_rdc = 1;
`else
      e_rc = 1; e_rd = 32'h0; e_er = 1'b1; e_rdc = 0;
`endif
      transact(1'b0, t_size[i], t_uns[i], t_addr[i], 32'h0, 1, 32'h80FF_7F01, 12'd4, rc, rd, er, rdc, rdb, wc, wcy, wa, wdt, r1, rr, ia);
      vectors++; if (rc !== e_rc || rd !== e_rd || er !== e_er) begin miscompares++; $display("FAIL ld_sub[%0d]: got cyc=%0d %h/%b want cyc=%0d %h/%b", i, rc, rd, er, e_rc, e_rd, e_er); end
      vectors++; if (rdc !== e_rdc || rdb !== 0) begin miscompares++; $display("FAIL ld_sub_rd[%0d]: got %0d/%0d want %0d/0", i, rdc, rdb, e_rdc); end
    end
  endtask

  task automatic test_store_word();
    transact(1'b1, 2'b10, 1'b0, 32'h40, 32'h1234_5678, 0, 32'h0, 12'd16, rc, rd, er, rdc, rdb, wc, wcy, wa, wdt, r1, rr, ia);
    vectors++; if (rc !== 2 || er !== 1'b0 || rd !== 32'h0) begin miscompares++; $display("FAIL stw_resp: got cyc=%0d %h/%b want 2 0/0", rc, rd, er); end
    vectors++; if (wc !== 1 || wcy !== 1 || wa !== 12'd16 || wdt !== 32'h1234_5678) begin miscompares++; $display("FAIL stw_write: got n=%0d cyc=%0d @%h=%h want 1 1 @010=12345678", wc, wcy, wa, wdt); end
    vectors++; if (rdc !== 0) begin miscompares++; $display("FAIL stw_no_read: got %0d want 0", rdc); end
  endtask

  // Old word 0x11223344 at word 8; half at 0x22 and byte at 0x21.
  task automatic test_store_subword();
    logic [31:0] t_addr [2] = '{32'h22, 32'h21};
    logic [1:0]  t_size [2] = '{2'b01, 2'b00};
    logic [31:0] t_wd   [2] = '{32'h0000_ABCD, 32'h0000_00EE};
    logic [31:0] t_exp  [2] = '{32'hABCD_3344, 32'h1122_EE44};
    for (int i = 0; i < 2; i++) begin
      int e_rc, e_wc, e_rdc;
`ifdef LSU_SUBWORD_EN
      e_rc = 5; e_wc = 1; e_rdc = 3;
`else
      e_rc = 1; e_wc = 0; e_rdc = 0;
`endif
      transact(1'b1, t_size[i], 1'b0, t_addr[i], t_wd[i], 3, 32'h1122_3344, 12'd8, rc, rd, er, rdc, rdb, wc, wcy, wa, wdt, r1, rr, ia);
      vectors++; if (rc !== e_rc || er !== (e_wc == 0) || rd !== 32'h0) begin miscompares++; $display("FAIL st_sub_resp[%0d]: got cyc=%0d %h/%b want cyc=%0d", i, rc, rd, er, e_rc); end
      vectors++; if (wc !== e_wc || rdc !== e_rdc || rdb !== 0) begin miscompares++; $display("FAIL st_sub_ops[%0d]: got wr=%0d rd=%0d bad=%0d want %0d/%0d/0", i, wc, rdc, rdb, e_wc, e_rdc); end
`ifdef LSU_SUBWORD_EN
      vectors++; if (wcy !== 4 || wa !== 12'd8 || wdt !== t_exp[i]) begin miscompares++; $display("FAIL st_sub_write[%0d]: got cyc=%0d @%h=%h want 4 @008=%h", i, wcy, wa, wdt, t_exp[i]); end
`endif
    end
  endtask

  task automatic test_errors();
    logic        t_we   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [1:0]  t_size [4] = '{2'b01, 2'b10, 2'b11, 2'b10};
    logic [31:0] t_addr [4] = '{32'h3, 32'h4000, 32'h0, 32'h2};
    for (int i = 0; i < 4; i++) begin
      transact(t_we[i], t_size[i], 1'b0, t_addr[i], 32'hFFFF_FFFF, 1, 32'h1, 12'd0, rc, rd, er, rdc, rdb, wc, wcy, wa, wdt, r1, rr, ia);
      vectors++; if (rc !== 1 || er !== 1'b1 || rd !== 32'h0) begin miscompares++; $display("FAIL err[%0d]: got cyc=%0d %h/%b want 1 0/1", i, rc, rd, er); end
      vectors++; if (rdc !== 0 || wc !== 0 || ia !== 1'b1) begin miscompares++; $display("FAIL err_mem[%0d]: got rd=%0d wr=%0d idle=%b want 0/0/1", i, rdc, wc, ia); end
    end
    transact(1'b0, 2'b10, 1'b0, 32'h3FFC, 32'h0, 1, 32'h0BAD_F00D, 12'hFFF, rc, rd, er, rdc, rdb, wc, wcy, wa, wdt, r1, rr, ia);
    vectors++; if (rc !== 2 || rd !== 32'h0BAD_F00D || er !== 1'b0 || rdb !== 0) begin miscompares++; $display("FAIL top_word: got cyc=%0d %h/%b bad=%0d want 2 0badf00d/0 0", rc, rd, er, rdb); end
  endtask

  task automatic test_timeout();
    transact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, 32'h0, 12'd4, rc, rd, er, rdc, rdb, wc, wcy, wa, wdt, r1, rr, ia);
    vectors++; if (rc !== 16 || er !== 1'b1 || rd !== 32'h0) begin miscompares++; $display("FAIL timeout_resp: got cyc=%0d %h/%b want 16 0/1", rc, rd, er); end
    vectors++; if (rdc !== 15) begin miscompares++; $display("FAIL timeout_wait: got %0d want 15", rdc); end
    mem_read_valid_i = 1'b1; mem_read_data_i = 32'h1357_9BDF;
    tick();
    mem_read_valid_i = 1'b0;
    for (int n = 0; n < 3; n++) begin
      vectors++; if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin miscompares++; $display("FAIL late_valid[%0d]: got resp=%b ready=%b want 0/1", n, resp_valid_o, req_ready_o); end
      tick();
    end
    // Valid on the final allowed cycle still wins over the timeout.
    transact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 15, 32'h2468_ACE0, 12'd4, rc, rd, er, rdc, rdb, wc, wcy, wa, wdt, r1, rr, ia);
    vectors++; if (rc !== 16 || er !== 1'b0 || rd !== 32'h2468_ACE0) begin miscompares++; $display("FAIL valid_at_limit: got cyc=%0d %h/%b want 16 2468ace0/0", rc, rd, er); end
`ifdef LSU_SUBWORD_EN
    transact(1'b1, 2'b00, 1'b0, 32'h21, 32'h77, 0, 32'h0, 12'd8, rc, rd, er, rdc, rdb, wc, wcy, wa, wdt, r1, rr, ia);
    vectors++; if (rc !== 16 || er !== 1'b1 || wc !== 0) begin miscompares++; $display("FAIL st_timeout: got cyc=%0d err=%b wr=%0d want 16/1/0", rc, er, wc); end
`endif
  endtask

  task automatic test_reset_mid();
    req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'b10; req_unsigned_i = 1'b0;
    req_addr_i = 32'h10; req_wdata_i = 32'h0;
    tick();
    req_valid_i = 1'b0;
    tick(); tick();
    vectors++; if (mem_read_en_o !== 1'b1 || req_ready_o !== 1'b0) begin miscompares++; $display("FAIL rmid_pre: got en=%b ready=%b want 1/0", mem_read_en_o, req_ready_o); end
    #2 rst_i = 1'b1;
    #1;
    vectors++; if (mem_read_en_o !== 1'b0 || req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin miscompares++; $display("FAIL rmid_async: got en=%b ready=%b resp=%b want 0/1/0", mem_read_en_o, req_ready_o, resp_valid_o); end
    tick();
    rst_i = 1'b0;
    mem_read_valid_i = 1'b1; mem_read_data_i = 32'hDEAD_BEEF;
    tick();
    mem_read_valid_i = 1'b0;
    for (int n = 0; n < 2; n++) begin
      vectors++; if (resp_valid_o !== 1'b0 || mem_read_en_o !== 1'b0 || req_ready_o !== 1'b1) begin miscompares++; $display("FAIL rmid_late[%0d]: got resp=%b en=%b ready=%b want 0/0/1", n, resp_valid_o, mem_read_en_o, req_ready_o); end
      tick();
    end
    transact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 32'hCAFE_F00D, 12'd4, rc, rd, er, rdc, rdb, wc, wcy, wa, wdt, r1, rr, ia);
    vectors++; if (rc !== 3 || rd !== 32'hCAFE_F00D || er !== 1'b0) begin miscompares++; $display("FAIL rmid_next: got cyc=%0d %h/%b want 3 cafef00d/0", rc, rd, er); end
  endtask

  task automatic test_back_to_back();
    transact(1'b1, 2'b10, 1'b0, 32'h8, 32'hA1B2_C3D4, 0, 32'h0, 12'd2, rc, rd, er, rdc, rdb, wc, wcy, wa, wdt, r1, rr, ia);
    vectors++; if ({r1, rr, ia} !== 3'b001 || rc !== 2) begin miscompares++; $display("FAIL b2b_first: got c1=%b resp=%b after=%b cyc=%0d want 0/0/1 2", r1, rr, ia, rc); end
    transact(1'b0, 2'b10, 1'b1, 32'hC, 32'h0, 1, 32'h0F0F_0F0F, 12'd3, rc, rd, er, rdc, rdb, wc, wcy, wa, wdt, r1, rr, ia);
    vectors++; if (rc !== 2 || rd !== 32'h0F0F_0F0F || er !== 1'b0 || rdb !== 0) begin miscompares++; $display("FAIL b2b_second: got cyc=%0d %h/%b bad=%0d want 2 0f0f0f0f/0 0", rc, rd, er, rdb); end
  endtask

  initial begin
    rst_i = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'b00;
    req_unsigned_i = 1'b0; req_addr_i = 32'h0; req_wdata_i = 32'h0;
    mem_read_valid_i = 1'b0; mem_read_data_i = 32'h0;
    tick(); tick();
    test_reset();
    rst_i = 1'b0;
    tick();
    test_load_word();
    test_load_subword();
    test_store_word();
    test_store_subword();
    test_errors();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu.md
# lsu

Load/store unit that sits between the CPU execute stage and the word-addressed data memory. It accepts one byte-addressed load or store at a time and translates it into word accesses on the memory read/write ports. Byte and halfword accesses are handled here: loads are extracted and sign- or zero-extended, and sub-word stores are done as read-modify-write. The unit waits out the memory's multi-cycle read latency, with a timeout guard.

## Interface
- NUMWORDS, 4096: words in the attached memory.
- DATAWIDTH, 32: word width; only 32 is supported.
- TIMEOUT, 15: maximum cycles in READ_WAIT before an error response.
- ADDR_SIZE (localparam), $clog2(NUMWORDS): memory word-address width.

- clk_i  in  1  clock
- rst_i  in  1  reset rst_i, asynchronous, active-high; clock clk_i
- req_valid_i  in  1  request present
- req_ready_o  out  1  unit can accept a request (high only in IDLE)
- req_we_i  in  1  1 = store, 0 = load
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned_i  in  1  load zero-extends when 1, sign-extends when 0
- req_addr_i  in  32  byte address
- req_wdata_i  in  32  store data, right-aligned
- resp_valid_o  out  1  one-cycle completion pulse
- resp_rdata_o  out  32  extended load data; 0 for stores and errors
- resp_err_o  out  1  misaligned, out-of-range, illegal size or timeout
- mem_read_en_o  out  1  memory read request, held as a level
- mem_read_addr_o  out  ADDR_SIZE  word address
- mem_read_valid_i  in  1  one-cycle pulse, read data valid
- mem_read_data_i  in  32  read word
- mem_write_en_o  out  1  one-cycle write strobe
- mem_write_addr_o  out  ADDR_SIZE  word address
- mem_write_data_o  out  32  full write word

## Operation
- States: IDLE, READ_WAIT, WRITE, RESP.
- Accept on req_valid_i & req_ready_o. On acceptance, register we, size, unsigned, addr and wdata.
- Word index is addr[ADDR_SIZE+1:2]; byte offset is addr[1:0]; lanes are little-endian.
- Checks at accept:
  - size 11 is illegal.
  - Half requires addr[0]=0.
  - Word requires addr[1:0]=0.
  - addr[31:ADDR_SIZE+2] must be 0.
- Any check failure: IDLE -> RESP with err=1, rdata=0; no memory access is issued.
- Load: IDLE -> READ_WAIT. On mem_read_valid_i -> RESP with extracted, extended data.
- Word store: IDLE -> WRITE. Write wdata in full -> RESP.
- Sub-word store: IDLE -> READ_WAIT. On valid, merge the new byte/half into the read word at the offset lane -> WRITE -> RESP.
- READ_WAIT:
  - mem_read_en_o=1 and mem_read_addr_o is stable for the whole state.
  - Timeout counter clears on entry and increments each cycle without valid.
  - When the counter reaches TIMEOUT-1 with no valid -> RESP with err=1, and the store write is skipped.
  - If valid and timeout occur in the same cycle, valid wins.
- A mem_read_valid_i outside READ_WAIT is ignored.
- RESP: resp_valid_o=1 for exactly one cycle -> IDLE.

## Timing
- Reset values: state IDLE, req_ready_o=1, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0, all mem_* outputs 0, counter 0.
- Accept at cycle 0. READ_WAIT or WRITE starts at cycle 1, with mem_*_en_o asserted in that cycle.
- Load: valid at cycle k gives resp_valid_o at cycle k+1.
- Word store: write strobe at cycle 1, response at cycle 2.
- Sub-word store: valid at cycle k, write at k+1, response at k+2.
- Error at accept: response at cycle 1.
- req_ready_o is low from cycle 1 until the cycle after resp_valid_o, so back-to-back requests are spaced by at least 2 cycles.
- Reset mid-operation: immediate return to IDLE; enables drop asynchronously; an abandoned read's late valid is ignored.

## Configuration
- LSU_SUBWORD_EN defined: byte and half accesses are supported as described.
- LSU_SUBWORD_EN undefined: size 00/01 is treated as illegal (err response at cycle 1); the merge and extract logic is omitted, and stores never enter READ_WAIT.

## Test plan
- Load word: addr 0x10, memory word 4 = 0xDEADBEEF, read delay 5. Expect mem_read_addr_o=4 from cycle 1, resp at cycle 7 with rdata=0xDEADBEEF, err=0.
- Signed byte load: addr 0x13, word = 0x80FF7F01. Expect rdata=0xFFFFFF80; the same load with unsigned=1 expects 0x00000080.
- Half store: addr 0x22, wdata 0x0000ABCD, old word 0x11223344. Expect one write of 0xABCD3344 to word 8, response err=0.
- Misaligned half: addr 0x3. Expect resp at cycle 1 with err=1, no mem enable ever asserted. With NUMWORDS=4096, addr 0x4000 also expects err=1.
- Timeout: memory never responds. Expect err=1 after TIMEOUT cycles in READ_WAIT; a late valid afterwards produces no response.
- Reset asserted during READ_WAIT. Expect mem_read_en_o=0 and req_ready_o=1 immediately; the next request completes normally.
